// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Transmit-side byte buffer placed directly upstream of uart_tx. Bytes written
// by the host are queued in a circular RAM and handed to uart_tx one at a time.
// Each byte is presented on tx_data one cycle before a single-cycle ready
// strobe. The next byte is not started until uart_tx has raised tdre (stop bit)
// and then dropped it again (back in idle).
//
// Parameters
//   DEPTH_LOG2 : log2 of FIFO depth (default 4 -> 16 entries)
//   WIDTH      : data width, must match uart_tx tx_data
//
// Ports
//   clk      in   1             system clock, rising edge
//   clr_n    in   1             asynchronous active-low reset
//   wr_en    in   1             host write strobe, one byte per cycle
//   wr_data  in   WIDTH         host byte
//   full     out  1             FIFO full, writes ignored while high
//   empty    out  1             FIFO empty
//   level    out  DEPTH_LOG2+1  number of stored bytes
//   busy     out  1             high whenever the FSM is not idle
//   tdre     in   1             from uart_tx, high during the stop bit
//   ready    out  1             to uart_tx, one-cycle start strobe
//   tx_data  out  WIDTH         to uart_tx, byte to send
//
// Optional feature (macro UART_TX_FIFO_OVF_EN):
//   ovf      out  1             sticky overflow flag, set after wr_en while full
//   ovf_clr  in   1             clears ovf (a coincident overflow wins)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  input  logic                  tdre,
  output logic                  ready,
  output logic [WIDTH-1:0]      tx_data
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                  ovf,
  input  logic                  ovf_clr
`endif
);

  localparam int                 DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] C_ONE   = (DEPTH_LOG2+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE,
    S_WAIT_DONE,
    S_WAIT_IDLE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [WIDTH-1:0]        r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_level;
  logic [DEPTH_LOG2:0]     w_level_nxt;
  logic                    r_full;
  logic                    r_empty;
  logic [WIDTH-1:0]        r_tx_data;
  logic                    w_push;
  logic                    w_pop;

  // Admission uses the registered full flag only; a pop in the same cycle
  // does not make room for a write that arrives while full.
  assign w_push = wr_en && !r_full;
  assign w_pop  = (r_state == S_STROBE);

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + C_ONE;
      2'b01:   w_level_nxt = r_level - C_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage RAM carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == C_DEPTH);
      r_empty <= (w_level_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // tdre is only looked at in the two wait states, so an unknown value from
  // a freshly reset uart_tx cannot disturb the other states.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (!r_empty) w_next = S_LOAD;
      S_LOAD:      w_next = S_STROBE;
      S_STROBE:    w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (tdre)     w_next = S_WAIT_IDLE;
      S_WAIT_IDLE: if (!tdre)    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // The head byte is captured on the edge that enters LOAD so that tx_data is
  // stable for the whole LOAD cycle, a full cycle before ready rises. The
  // entry is not popped until STROBE, so a write can never overwrite it here.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                           r_tx_data <= '0;
    else if (r_state == S_IDLE && !r_empty) r_tx_data <= r_mem[r_rd_ptr];
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)               r_ovf <= 1'b0;
    else if (wr_en && r_full) r_ovf <= 1'b1;
    else if (ovf_clr)         r_ovf <= 1'b0;
  end

  assign ovf = r_ovf;
`endif

  assign full    = r_full;
  assign empty   = r_empty;
  assign level   = r_level;
  assign busy    = (r_state != S_IDLE);
  assign ready   = (r_state == S_STROBE);
  assign tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed self-checking bench for uart_tx_fifo. A small uart_tx stand-in
// records every byte strobed by ready and answers with a tdre rise/fall pair;
// scenarios that need exact tdre timing drive tdre by hand instead.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic       clk;
  logic       clr_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       busy;
  logic       tdre;
  logic       ready;
  logic [7:0] tx_data;
`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf;
  logic       ovf_clr;
`endif

  logic       tdre_man;
  logic       tdre_mod;
  logic       model_en;
  logic [7:0] cap_q [$];

  int n_tests;
  int n_fail;

  assign tdre = model_en ? tdre_mod : tdre_man;

  uart_tx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .busy    (busy),
    .tdre    (tdre),
    .ready   (ready),
    .tx_data (tx_data)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart_tx stand-in: capture byte on ready, stop bit a few cycles later.
  initial begin
    tdre_mod = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (model_en && ready === 1'b1) begin
        cap_q.push_back(tx_data);
        repeat (3) @(posedge clk);
        #2 tdre_mod = 1'b1;
        repeat (2) @(posedge clk);
        #2 tdre_mod = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_tests++; if (level !== 5'd0)   begin n_fail++; $display("FAIL reset_level act=%0d exp=0", level); end
    n_tests++; if (empty !== 1'b1)   begin n_fail++; $display("FAIL reset_empty act=%b exp=1", empty); end
    n_tests++; if (full !== 1'b0)    begin n_fail++; $display("FAIL reset_full act=%b exp=0", full); end
    n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy act=%b exp=0", busy); end
    n_tests++; if (ready !== 1'b0)   begin n_fail++; $display("FAIL reset_ready act=%b exp=0", ready); end
    n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_txdata act=%h exp=00", tx_data); end
`ifdef UART_TX_FIFO_OVF_EN
    n_tests++; if (ovf !== 1'b0)     begin n_fail++; $display("FAIL reset_ovf act=%b exp=0", ovf); end
`endif
    clr_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    n_tests++; if (level !== 5'd1 || ready !== 1'b0) begin n_fail++; $display("FAIL single_wr level=%0d ready=%b exp 1/0", level, ready); end
    tick();
    n_tests++; if (ready !== 1'b0 || tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_load ready=%b tx=%h exp 0/a5", ready, tx_data); end
    tick();
    n_tests++; if (ready !== 1'b1 || tx_data !== 8'hA5 || level !== 5'd1) begin n_fail++; $display("FAIL single_strobe ready=%b tx=%h level=%0d exp 1/a5/1", ready, tx_data, level); end
    tick();
    n_tests++; if (ready !== 1'b0 || level !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL single_pop ready=%b level=%0d empty=%b exp 0/0/1", ready, level, empty); end
    tdre_man = 1'b1;
    tick();
    tick();
    tdre_man = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL single_idle busy=%b ready=%b exp 0/0", busy, ready); end
  endtask

  task automatic test_fill_overflow();
    int base;
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    repeat (3) tick();
    n_tests++; if (busy !== 1'b1 || empty !== 1'b1) begin n_fail++; $display("FAIL fill_hold busy=%b empty=%b exp 1/1", busy, empty); end
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    n_tests++; if (level !== 5'd16 || full !== 1'b1 || empty !== 1'b0) begin n_fail++; $display("FAIL fill_full level=%0d full=%b empty=%b exp 16/1/0", level, full, empty); end
    wr_en = 1'b1; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    n_tests++; if (level !== 5'd16 || full !== 1'b1) begin n_fail++; $display("FAIL ovf_drop level=%0d full=%b exp 16/1", level, full); end
`ifdef UART_TX_FIFO_OVF_EN
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set act=%b exp=1", ovf); end
    tick();
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky act=%b exp=1", ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear act=%b exp=0", ovf); end
    ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
    tick();
    ovf_clr = 1'b0; wr_en = 1'b0;
    n_tests++; if (ovf !== 1'b1 || level !== 5'd16) begin n_fail++; $display("FAIL ovf_setwins ovf=%b level=%0d exp 1/16", ovf, level); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
`endif
    tdre_man = 1'b1;
    tick();
    tick();
    tdre_man = 1'b0;
    tick();
    base = cap_q.size();
    model_en = 1'b1;
    for (int c = 0; c < 400 && !(cap_q.size() == base + 16 && busy == 1'b0); c++) tick();
    repeat (20) tick();
    n_tests++; if (cap_q.size() != base + 16) begin n_fail++; $display("FAIL drain_count act=%0d exp=16", cap_q.size() - base); end
    for (int i = 0; i < 16; i++) begin
      if (base + i < cap_q.size()) begin
        n_tests++; if (cap_q[base+i] !== 8'(i + 1)) begin n_fail++; $display("FAIL drain_order[%0d] act=%h exp=%h", i, cap_q[base+i], 8'(i + 1)); end
      end
    end
    n_tests++; if (empty !== 1'b1 || level !== 5'd0) begin n_fail++; $display("FAIL drain_empty empty=%b level=%0d exp 1/0", empty, level); end
  endtask

  task automatic test_write_during_pop();
    int base;
    base = cap_q.size();
    wr_en = 1'b1; wr_data = 8'h41;
    tick();
    n_tests++; if (level !== 5'd1) begin n_fail++; $display("FAIL wdp_l1 act=%0d exp=1", level); end
    wr_data = 8'h42;
    tick();
    n_tests++; if (level !== 5'd2 || ready !== 1'b0 || tx_data !== 8'h41) begin n_fail++; $display("FAIL wdp_load level=%0d ready=%b tx=%h exp 2/0/41", level, ready, tx_data); end
    wr_data = 8'h43;
    tick();
    n_tests++; if (level !== 5'd3 || ready !== 1'b1) begin n_fail++; $display("FAIL wdp_strobe level=%0d ready=%b exp 3/1", level, ready); end
    wr_data = 8'h44;
    tick();
    wr_en = 1'b0;
    n_tests++; if (level !== 5'd3 || ready !== 1'b0) begin n_fail++; $display("FAIL wdp_same level=%0d ready=%b exp 3/0", level, ready); end
    for (int c = 0; c < 200 && !(cap_q.size() == base + 4 && busy == 1'b0); c++) tick();
    repeat (10) tick();
    n_tests++; if (cap_q.size() != base + 4) begin n_fail++; $display("FAIL wrap_count act=%0d exp=4", cap_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < cap_q.size()) begin
        n_tests++; if (cap_q[base+i] !== 8'(8'h41 + i)) begin n_fail++; $display("FAIL wrap_order[%0d] act=%h exp=%h", i, cap_q[base+i], 8'(8'h41 + i)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nready;
    int nbusy;
    model_en = 1'b0;
    tdre_man = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h61 + i);
      tick();
    end
    wr_en = 1'b0;
    n_tests++; if (level !== 5'd5 || busy !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL rmid_pre level=%0d busy=%b ready=%b exp 5/1/0", level, busy, ready); end
    #1 clr_n = 1'b0;
    #1;
    n_tests++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL rmid_fifo level=%0d empty=%b full=%b exp 0/1/0", level, empty, full); end
    n_tests++; if (busy !== 1'b0 || ready !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rmid_fsm busy=%b ready=%b tx=%h exp 0/0/00", busy, ready, tx_data); end
    tdre_man = 1'bx;
    tick();
    tick();
    clr_n = 1'b1;
    nready = 0;
    nbusy = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ready !== 1'b0) nready++;
      if (busy !== 1'b0) nbusy++;
    end
    n_tests++; if (nready != 0 || nbusy != 0) begin n_fail++; $display("FAIL rmid_quiet ready_cycles=%0d busy_cycles=%0d exp 0/0", nready, nbusy); end
    tdre_man = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    tick();
    n_tests++; if (tx_data !== 8'h77 || ready !== 1'b0) begin n_fail++; $display("FAIL rmid_load tx=%h ready=%b exp 77/0", tx_data, ready); end
    tick();
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rmid_strobe act=%b exp=1", ready); end
    tick();
    tdre_man = 1'b1;
    tick();
    tdre_man = 1'b0;
    tick();
  endtask

  task automatic test_tdre_stuck();
    int nready;
    int nidle;
    wr_en = 1'b1; wr_data = 8'h81;
    tick();
    wr_data = 8'h82;
    tick();
    wr_en = 1'b0;
    tick();
    n_tests++; if (ready !== 1'b1 || tx_data !== 8'h81) begin n_fail++; $display("FAIL stuck_first ready=%b tx=%h exp 1/81", ready, tx_data); end
    tick();
    tdre_man = 1'b1;
    nready = 0;
    nidle = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ready !== 1'b0) nready++;
      if (busy !== 1'b1) nidle++;
    end
    n_tests++; if (nready != 0 || nidle != 0 || level !== 5'd1) begin n_fail++; $display("FAIL stuck_hold ready_cycles=%0d idle_cycles=%0d level=%0d exp 0/0/1", nready, nidle, level); end
    tdre_man = 1'b0;
    tick();
    tick();
    n_tests++; if (tx_data !== 8'h82 || ready !== 1'b0) begin n_fail++; $display("FAIL stuck_load tx=%h ready=%b exp 82/0", tx_data, ready); end
    tick();
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL stuck_strobe act=%b exp=1", ready); end
    tick();
    tdre_man = 1'b1;
    tick();
    tdre_man = 1'b0;
    tick();
    tick();
    n_tests++; if (busy !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL stuck_end busy=%b empty=%b exp 0/1", busy, empty); end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    clr_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    tdre_man = 1'b0;
    model_en = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr  = 1'b0;
`endif
    test_reset();
    test_single();
    test_fill_overflow();
    test_write_during_pop();
    test_reset_mid();
    test_tdre_stuck();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
